// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the 4-requester arbiter
package arb_pkg;

   localparam int NREQ = 4;
   localparam int ID_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NREQ-1:0] v;
      v = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/req_arbiter_4_if.sv
// rtl/req_arbiter_4_if.sv - request/grant bundle between requesters and the arbiter
interface req_arbiter_4_if;
   import arb_pkg::*;

   logic [NREQ-1:0] req;
   logic            release_i;
   logic            rr_en;
   logic [NREQ-1:0] gnt;
   logic [ID_W-1:0] gnt_id;
   logic            gnt_valid;
   logic            timeout_o;

   modport master (
      output req, release_i, rr_en,
      input  gnt, gnt_id, gnt_valid, timeout_o
   );

   modport slave (
      input  req, release_i, rr_en,
      output gnt, gnt_id, gnt_valid, timeout_o
   );

endinterface

// File: rtl/rot_prio_enc4.sv
// rtl/rot_prio_enc4.sv - rotating 4-to-2 priority encoder, top_id holds highest priority
module rot_prio_enc4
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] top_id,
   output logic [ID_W-1:0] win_id,
   output logic            any
);

   logic [NREQ-1:0] rot;
   logic [ID_W-1:0] idx;
   logic [ID_W-1:0] rot_win;

   // Bit j of rot is requester (j + top_id + 1) mod 4, so rot[3] is top_id.
   always_comb begin
      rot     = '0;
      idx     = '0;
      rot_win = '0;
      for (int j = 0; j < NREQ; j++) begin
         idx    = ID_W'(j) + top_id + ID_W'(1);
         rot[j] = req[idx];
      end
      for (int j = 0; j < NREQ; j++) begin
         if (rot[j]) rot_win = ID_W'(j);
      end
   end

   assign win_id = rot_win + top_id + ID_W'(1);
   assign any    = |req;

endmodule

// File: rtl/req_arbiter_4.sv
// rtl/req_arbiter_4.sv - four-requester fixed/round-robin arbiter with hold-time limit
module req_arbiter_4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   req_arbiter_4_if.slave   bus
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

   state_t          state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [ID_W-1:0] last_q, last_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0] gnt_id_q, gnt_id_d;
   logic            valid_q, valid_d;
   logic            timeout_q, timeout_d;

   logic [ID_W-1:0] top_id;
   logic [ID_W-1:0] win_id;
   logic            win_any;
   logic            normal_rel;
   logic            expire;

   assign top_id = bus.rr_en ? (last_q - ID_W'(1)) : ID_W'(NREQ - 1);

   rot_prio_enc4 u_enc (
      .req    (bus.req),
      .top_id (top_id),
      .win_id (win_id),
      .any    (win_any)
   );

   assign normal_rel = bus.release_i || !bus.req[gnt_id_q];
   assign expire     = (hold_q == MAX_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         last_q    <= '0;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_any) state_d = GRANT;
         GRANT:   if (normal_rel || expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Release is checked before expiry so a coincident release suppresses the timeout pulse.
   always_comb begin
      hold_d    = hold_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d    = '0;
            gnt_id_d = '0;
            valid_d  = 1'b0;
            if (win_any) begin
               gnt_d    = onehot(win_id);
               gnt_id_d = win_id;
               valid_d  = 1'b1;
               hold_d   = CNT_W'(1);
               last_d   = win_id;
            end
         end
         GRANT: begin
            if (normal_rel || expire) begin
               gnt_d     = '0;
               gnt_id_d  = '0;
               valid_d   = 1'b0;
               hold_d    = '0;
               timeout_d = !normal_rel;
            end else begin
               hold_d = hold_q + CNT_W'(1);
            end
         end
         default: begin
            gnt_d    = '0;
            gnt_id_d = '0;
            valid_d  = 1'b0;
            hold_d   = '0;
         end
      endcase
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = valid_q;
   assign bus.timeout_o = timeout_q;

endmodule
